// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT input frame buffer.
package fft_pkg;

  localparam int SAMPLE_COUNT = 4096;
  localparam int ADDR_W       = $clog2(SAMPLE_COUNT);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// AXI-Stream link from the frame buffer to the FFT core.
interface fft_frame_buffer_if #(
  parameter int OUT_WIDTH = 16
);
  logic [2*OUT_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; bank select is the address MSB.
module frame_bank_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 13
) (
  input  logic                  clk_in,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame collector between the Hanning window and the FFT core.
// Read FSM:  IDLE | no full bank being streamed
//            PRIME | first RAM read in flight, output register loads next
//            STREAM | beats flowing through output register + skid slot
module fft_frame_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int SAMPLE_COUNT = fft_pkg::SAMPLE_COUNT,
  parameter int OUT_WIDTH    = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [DATA_WIDTH-1:0]  in_sample,
  input  logic                   in_valid,
  fft_frame_buffer_if.master     m_axis,
  output logic                   frame_dropped,
  output logic [7:0]             drop_count,
  output logic                   wr_active
);
  import fft_pkg::*;

  localparam int               IDX_W    = $clog2(SAMPLE_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_COUNT - 1);
  localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(SAMPLE_COUNT - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);

  function automatic logic [2*OUT_WIDTH-1:0] widen(input logic [DATA_WIDTH-1:0] s);
    logic signed [OUT_WIDTH-1:0] re;
    re = OUT_WIDTH'($signed(s));
    return {{OUT_WIDTH{1'b0}}, re};
  endfunction

  bank_state_t bank_st [2];

  logic [IDX_W-1:0] wr_idx;
  logic             wr_bank, last_wr_bank, last_full_bank;
  logic             frame_start, claim_ok, claim_bank, pref_bank;
  logic             wr_en;
  logic [IDX_W:0]   wr_addr;

  rd_state_t             rd_state;
  logic                  rd_bank;
  logic [IDX_W:0]        rd_cnt;
  logic                  pend, pend_last;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_v, skid_last;
  logic [2*OUT_WIDTH-1:0] out_data;
  logic                  out_v, out_last;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  pop, frame_end, any_full, sel_bank, other_full, room;
  logic [1:0]            occ;
  logic                  rd_en;
  logic [IDX_W:0]        rd_addr;

  // Frame start: prefer the bank after the last one written, else the other one.
  always_comb begin
    frame_start = in_valid && (wr_idx == '0);
    pref_bank   = ~last_wr_bank;
    claim_bank  = pref_bank;
    claim_ok    = 1'b1;
    if (bank_st[pref_bank] != EMPTY) begin
      claim_bank = ~pref_bank;
      claim_ok   = (bank_st[~pref_bank] == EMPTY);
    end
    wr_en   = in_valid && (frame_start ? claim_ok : wr_active);
    wr_addr = {(frame_start ? claim_bank : wr_bank), wr_idx};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bank_st[0]     <= EMPTY;
      bank_st[1]     <= EMPTY;
      wr_idx         <= '0;
      wr_bank        <= 1'b0;
      last_wr_bank   <= 1'b1;
      last_full_bank <= 1'b1;
      wr_active      <= 1'b0;
      frame_dropped  <= 1'b0;
      drop_count     <= 8'd0;
    end else begin
      frame_dropped <= 1'b0;
      if (frame_end) bank_st[rd_bank] <= EMPTY;
      if (in_valid) begin
        wr_idx <= wr_idx + 1'b1;
        if (frame_start) begin
          if (claim_ok) begin
            bank_st[claim_bank] <= FILLING;
            wr_bank             <= claim_bank;
            last_wr_bank        <= claim_bank;
            wr_active           <= 1'b1;
          end else begin
            wr_active     <= 1'b0;
            frame_dropped <= 1'b1;
            drop_count    <= sat_inc8(drop_count);
          end
        end else if (wr_active && (wr_idx == LAST_IDX)) begin
          bank_st[wr_bank] <= FULL;
          last_full_bank   <= wr_bank;
          wr_active        <= 1'b0;
        end
      end
    end
  end

  frame_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (IDX_W + 1)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_sample),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // A read is issued only if output, skid and in-flight slots cannot exceed two.
  always_comb begin
    pop        = out_v && m_axis.tready;
    frame_end  = pop && out_last;
    other_full = (bank_st[~rd_bank] == FULL);
    any_full   = (bank_st[0] == FULL) || (bank_st[1] == FULL);
    if ((bank_st[0] == FULL) && (bank_st[1] == FULL)) sel_bank = ~last_full_bank;
    else                                              sel_bank = (bank_st[1] == FULL);
    occ     = 2'(out_v) + 2'(skid_v) + 2'(pend);
    room    = (occ <= (2'(pop) + 2'd1));
    rd_en   = 1'b0;
    rd_addr = {rd_bank, rd_cnt[IDX_W-1:0]};
    case (rd_state)
      IDLE: begin
        if (any_full) begin
          rd_en   = 1'b1;
          rd_addr = {sel_bank, {IDX_W{1'b0}}};
        end
      end
      default: begin
        if (frame_end) begin
          rd_en   = other_full;
          rd_addr = {~rd_bank, {IDX_W{1'b0}}};
        end else begin
          rd_en = !rd_cnt[IDX_W] && room;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_state  <= IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      skid_data <= '0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
      out_data  <= '0;
      out_v     <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      pend <= rd_en;
      case (rd_state)
        IDLE: begin
          if (any_full) begin
            rd_state  <= PRIME;
            rd_bank   <= sel_bank;
            rd_cnt    <= CNT_ONE;
            pend_last <= 1'b0;
          end
        end
        default: begin
          if (frame_end) begin
            out_v     <= 1'b0;
            out_last  <= 1'b0;
            skid_v    <= 1'b0;
            pend_last <= 1'b0;
            if (other_full) begin
              rd_state <= PRIME;
              rd_bank  <= ~rd_bank;
              rd_cnt   <= CNT_ONE;
            end else begin
              rd_state <= IDLE;
            end
          end else begin
            rd_state  <= STREAM;
            rd_cnt    <= rd_cnt + {{IDX_W{1'b0}}, rd_en};
            pend_last <= rd_en && (rd_cnt == CNT_LAST);
            if (!out_v || pop) begin
              if (skid_v) begin
                out_data  <= widen(skid_data);
                out_last  <= skid_last;
                out_v     <= 1'b1;
                skid_v    <= pend;
                skid_data <= ram_q;
                skid_last <= pend_last;
              end else begin
                out_v    <= pend;
                out_last <= pend && pend_last;
                if (pend) out_data <= widen(ram_q);
              end
            end else if (pend) begin
              skid_v    <= 1'b1;
              skid_data <= ram_q;
              skid_last <= pend_last;
            end
          end
        end
      endcase
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_v;
  assign m_axis.tlast  = out_last;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer with a queue-based frame model.
module tb_fft_frame_buffer;
  localparam int DW = 8;
  localparam int SC = 16;
  localparam int OW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          frame_dropped;
  logic [7:0]    drop_count;
  logic          wr_active;

  fft_frame_buffer_if #(.OUT_WIDTH(OW)) m_axis ();

  fft_frame_buffer #(
    .DATA_WIDTH   (DW),
    .SAMPLE_COUNT (SC),
    .OUT_WIDTH    (OW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_sample     (in_sample),
    .in_valid      (in_valid),
    .m_axis        (m_axis),
    .frame_dropped (frame_dropped),
    .drop_count    (drop_count),
    .wr_active     (wr_active)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cplx(input logic [7:0] s);
    int v;
    v = $signed(s);
    return {16'h0000, v[15:0]};
  endfunction

  // Reference model: frames occupy one of two slots from start until last beat leaves.
  int          md_idx = 0;
  int          md_held = 0;
  bit          md_accept = 0;
  int          md_drops = 0;
  logic [32:0] md_part[$];
  logic [32:0] expq[$];
  bit          exp_drop = 0;
  bit          exp_wr = 0;
  bit          stalled = 0;
  logic [32:0] stall_word;
  bit          chk_en = 0;

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("frame_dropped", frame_dropped, exp_drop);
      check("drop_count", drop_count, md_drops);
      check("wr_active", wr_active, exp_wr);
      if (stalled) begin
        check("stall_valid", m_axis.tvalid, 1);
        check("stall_data", {m_axis.tlast, m_axis.tdata}, stall_word);
      end
    end
    if (rst_in) begin
      md_idx = 0; md_held = 0; md_accept = 0; md_drops = 0;
      md_part.delete(); expq.delete();
      exp_drop = 0; exp_wr = 0; stalled = 0;
    end else begin
      exp_drop = 0;
      if (in_valid) begin
        if (md_idx == 0) begin
          if (md_held < 2) begin
            md_held++; md_accept = 1; md_part.delete();
          end else begin
            md_accept = 0; exp_drop = 1;
            if (md_drops < 255) md_drops++;
          end
        end
        if (md_accept) begin
          md_part.push_back({(md_idx == SC-1), cplx(in_sample)});
          if (md_idx == SC-1) begin
            foreach (md_part[k]) expq.push_back(md_part[k]);
            md_part.delete();
            md_accept = 0;
          end
        end
        md_idx = (md_idx + 1) % SC;
      end
      exp_wr = md_accept;
      if (m_axis.tvalid && m_axis.tready) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", {m_axis.tlast, m_axis.tdata}, 33'h1_FFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = expq.pop_front();
          check("beat", {m_axis.tlast, m_axis.tdata}, e);
          if (e[32]) md_held--;
        end
        stalled = 0;
      end else begin
        stalled = m_axis.tvalid;
        stall_word = {m_axis.tlast, m_axis.tdata};
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input int gap);
    in_valid = 1'b1; in_sample = s;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!m_axis.tvalid && n < limit) begin tick(); n++; end
    check("wait_valid", m_axis.tvalid, 1);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    m_axis.tready = 1'b1; in_valid = 1'b0;
    while ((expq.size() != 0 || m_axis.tvalid) && n < limit) begin tick(); n++; end
    check("drain_empty", expq.size(), 0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_axis.tvalid, 0);
    check({tag, "_tlast"}, m_axis.tlast, 0);
    check({tag, "_tdata"}, m_axis.tdata, 0);
    check({tag, "_dropped"}, frame_dropped, 0);
    check({tag, "_drop_count"}, drop_count, 0);
    check({tag, "_wr_active"}, wr_active, 0);
  endtask

  typedef struct {
    logic [7:0]  sample;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t        vecs[SC];
  logic [7:0]  keep[SC];

  initial begin
    vecs[0]  = '{8'h80, 32'h0000_FF80, 1'b0};
    vecs[1]  = '{8'h7F, 32'h0000_007F, 1'b0};
    vecs[2]  = '{8'h00, 32'h0000_0000, 1'b0};
    vecs[3]  = '{8'hFF, 32'h0000_FFFF, 1'b0};
    vecs[4]  = '{8'h01, 32'h0000_0001, 1'b0};
    vecs[5]  = '{8'hFE, 32'h0000_FFFE, 1'b0};
    vecs[6]  = '{8'h40, 32'h0000_0040, 1'b0};
    vecs[7]  = '{8'hC0, 32'h0000_FFC0, 1'b0};
    vecs[8]  = '{8'h7E, 32'h0000_007E, 1'b0};
    vecs[9]  = '{8'h81, 32'h0000_FF81, 1'b0};
    vecs[10] = '{8'h10, 32'h0000_0010, 1'b0};
    vecs[11] = '{8'hF0, 32'h0000_FFF0, 1'b0};
    vecs[12] = '{8'h55, 32'h0000_0055, 1'b0};
    vecs[13] = '{8'hAA, 32'h0000_FFAA, 1'b0};
    vecs[14] = '{8'h02, 32'h0000_0002, 1'b0};
    vecs[15] = '{8'hFD, 32'h0000_FFFD, 1'b1};

    rst_in = 1'b1; in_valid = 1'b0; in_sample = '0; m_axis.tready = 1'b1;
    tick(); tick();
    chk_en = 1;
    tick();
    rst_in = 1'b0;
    check_reset_outputs("reset");

    // Ramp -8..7 every third cycle, then latency and back-to-back beats.
    for (int i = 0; i < SC - 1; i++) send(8'(i - 8), 2);
    in_valid = 1'b1; in_sample = 8'(7);
    tick();
    in_valid = 1'b0;
    check("lat_e0", m_axis.tvalid, 0);
    tick();
    check("lat_e1", m_axis.tvalid, 0);
    tick();
    check("lat_e2", m_axis.tvalid, 1);
    for (int i = 0; i < SC; i++) begin
      check("b2b_valid", m_axis.tvalid, 1);
      check("ramp_data", m_axis.tdata, cplx(8'(i - 8)));
      check("ramp_tlast", m_axis.tlast, (i == SC - 1));
      tick();
    end
    check("ramp_after", m_axis.tvalid, 0);

    // Sign-extension table.
    for (int i = 0; i < SC; i++) send(vecs[i].sample, 0);
    wait_valid(10);
    for (int i = 0; i < SC; i++) begin
      check("vec_data", m_axis.tdata, vecs[i].exp_data);
      check("vec_last", m_axis.tlast, vecs[i].exp_last);
      tick();
    end

    // Backpressure: frames 1 and 2 buffered, frame 3 dropped.
    m_axis.tready = 1'b0;
    for (int i = 0; i < 3 * SC; i++) send(8'($urandom), 0);
    check("bp_valid_held", m_axis.tvalid, 1);
    check("bp_drop_count", drop_count, 1);
    drain(200);
    check("bp_drop_count_after", drop_count, 1);

    // Random traffic with random ready.
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_sample = 8'($urandom);
      m_axis.tready = $urandom_range(0, 1) == 1;
      tick();
    end
    drain(300);

    // Reset at write index 7.
    do_reset();
    for (int i = 0; i < 7; i++) send(8'($urandom), 0);
    rst_in = 1'b1; in_valid = 1'b1; in_sample = 8'h33;
    tick();
    rst_in = 1'b0; in_valid = 1'b0;
    tick();
    check_reset_outputs("rst_wr");
    for (int i = 0; i < SC; i++) send(8'(i * 5 + 1), 0);
    drain(100);

    // Reset while beat 4 is on the output.
    for (int i = 0; i < SC; i++) begin keep[i] = 8'($urandom); send(keep[i], 0); end
    wait_valid(10);
    repeat (4) tick();
    check("rd_beat4", m_axis.tdata, cplx(keep[4]));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_reset_outputs("rst_rd");
    for (int i = 0; i < 30; i++) begin
      check("rst_rd_quiet", m_axis.tvalid, 0);
      tick();
    end
    for (int i = 0; i < SC; i++) send(8'(100 - i), 0);
    drain(100);

    // Drop counter saturation.
    do_reset();
    m_axis.tready = 1'b0;
    for (int f = 0; f < 300; f++)
      for (int i = 0; i < SC; i++) send(8'(f + i), 0);
    check("sat_drop_count", drop_count, 255);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Sits directly downstream of the Hanning window stage and upstream of the Xilinx FFT IP.
- Collects windowed signed samples, one per input strobe, into SAMPLE_COUNT-long frames using two ping-pong banks.
- Streams each complete frame out on an AXI-Stream master with tlast on the final sample; the second bank absorbs FFT backpressure.
- Frame boundaries stay aligned to the window's coefficient counter: input samples are counted modulo SAMPLE_COUNT from reset, and a frame is either written in full or dropped in full.

Parameters:
DATA_WIDTH, 8, width of the signed input sample.
SAMPLE_COUNT, 4096, samples per frame; must be a power of two, minimum 8.
OUT_WIDTH, 16, width of the real part on the output; the sample is sign-extended to this width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
in_sample  input  DATA_WIDTH  signed windowed sample
in_valid  input  1  one-cycle strobe; the sample is present this cycle
m_tdata  output  2*OUT_WIDTH  {imag = 0, real = sign-extended sample}
m_tvalid  output  1  AXI-Stream valid
m_tready  input  1  AXI-Stream ready from the FFT
m_tlast  output  1  high with sample index SAMPLE_COUNT-1
frame_dropped  output  1  one-cycle pulse when an input frame is discarded
drop_count  output  8  saturating count of dropped frames
wr_active  output  1  high while the current input frame is being stored

Behaviour:
- One clock is used throughout. Reset is synchronous and active-high on rst_in, clock clk_in.
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, frame_dropped=0, drop_count=0, wr_active=0.
  - Both banks are marked empty; wr_idx=0; the read FSM is IDLE.
  - Reset mid-frame discards all buffered data. No m_tlast is issued for a partial frame.
- Write side:
  - wr_idx (log2 SAMPLE_COUNT bits) increments on every in_valid and wraps to 0. Nothing happens on cycles without in_valid.
  - On in_valid with wr_idx==0, a frame starts:
    - If a bank is empty, claim it and write. Prefer the bank after the last one written; if that bank is not empty, take the other.
    - If no bank is empty, the whole frame is dropped: pulse frame_dropped; drop_count increments and saturates at 255; wr_active=0 for the frame.
  - While wr_active, sample k is written to bank[k].
  - When the sample with wr_idx==SAMPLE_COUNT-1 is written, the bank becomes FULL and wr_active drops the next cycle.
- Simultaneous events: a bank freed by the reader in cycle t is claimable by a frame start in cycle t+1, not in cycle t.
- Read FSM states:
  - IDLE: when any bank is FULL, select the oldest FULL bank, go to PRIME, and issue a read of address 0.
  - PRIME: one cycle covering the 1-cycle RAM latency. Load the output register; m_tvalid=1. Go to STREAM.
  - STREAM: on m_tvalid && m_tready, advance.
    - A 2-entry skid register between RAM and output gives full throughput: one sample per cycle while m_tready is held high, with no bubbles.
    - m_tdata and m_tvalid stay stable while m_tready=0.
    - The transfer of index SAMPLE_COUNT-1 carries m_tlast=1. On that transfer the bank becomes EMPTY.
    - Next state is PRIME if the other bank is FULL; otherwise IDLE.
- Latency: when the reader is IDLE, m_tvalid rises 2 cycles after the clock edge that writes the last sample.
- Arithmetic: the real part is the sign extension of in_sample to OUT_WIDTH; the imaginary half is all zeros. No scaling.
- No bank is ever read and written simultaneously.

Decomposition:
- Package fft_pkg holds:
  - SAMPLE_COUNT, with ADDR_W = $clog2(SAMPLE_COUNT);
  - typedef enum {IDLE, PRIME, STREAM} rd_state_t;
  - typedef enum {EMPTY, FILLING, FULL} bank_state_t.
- Sub-module frame_bank_ram: simple dual-port RAM on one clock with 1-cycle read latency.
  - Depth 2*SAMPLE_COUNT; the bank select is the address MSB.
  - Infers BRAM; no init file.

Test Plan:
- SAMPLE_COUNT=16, m_tready=1, 16 strobes with samples -8..7 every 3 cycles → after the last write, m_tvalid rises 2 cycles later; 16 back-to-back beats with real = 0xFFF8..0x0007 and imag = 0; m_tlast only on beat 15.
- Sign extension: input 8'h80 → real 16'hFF80; input 8'h7F → real 16'h007F.
- Backpressure: m_tready=0 for 40 cycles while frames 1 and 2 fill → frame 2 is held in the second bank and frame 3 is dropped (frame_dropped pulse, drop_count=1). Releasing ready yields frames 1 then 2 intact.
- Saturation: hold m_tready=0 through 300 frame starts → drop_count stops at 255.
- Random m_tready toggling at 50% → the output sequence equals the input sequence per frame, and m_tdata stays stable while stalled.
- Assert rst_in at write index 7 of frame 1 and during read beat 4 → all outputs return to reset values. The next in_valid is treated as index 0, and no stale data or tlast appears.
